// File: rtl/tx_sbinit.sv
// tx_sbinit: initiator half of the LTSM SBINIT step (start pattern, out-of-reset, done handshake).
// Define SBINIT_TIMEOUT_EN to build the SBINIT timeout counter and retry lockout.
module tx_sbinit #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_SBINIT_en,
    input  logic                    i_SB_pattern_detected,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_deassert_valid,
    output logic                    o_start_pattern_req,
    output logic                    o_valid_tx,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
    output logic                    o_SBINIT_end_tx,
    output logic                    o_SBINIT_timeout
);

    localparam logic [SB_MSG_WIDTH-1:0] MSG_NONE          = '0;
    localparam logic [SB_MSG_WIDTH-1:0] MSG_OUT_OF_RESET  = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_DONE_REQ      = SB_MSG_WIDTH'(2);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_DONE_RESP     = SB_MSG_WIDTH'(3);

    typedef enum logic [2:0] {
        IDLE,
        START_SB_PATTERN,
        SBINIT_OUT_OF_RESET,
        SBINIT_DONE_REQ,
        SBINIT_END
    } state_t;

    state_t state, state_d;
    logic   sent, sent_d;
    logic   rcvd, rcvd_d;
    logic   timeout_d;

`ifdef SBINIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt, cnt_d;
    logic             lockout, lockout_d;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state;
        sent_d    = sent;
        rcvd_d    = rcvd;
        timeout_d = 1'b0;
`ifdef SBINIT_TIMEOUT_EN
        cnt_d     = cnt;
        lockout_d = lockout;
`endif

        unique case (state)
            IDLE: begin
`ifdef SBINIT_TIMEOUT_EN
                if (!i_SBINIT_en)
                    lockout_d = 1'b0;
                else if (!lockout)
                    state_d = START_SB_PATTERN;
`else
                if (i_SBINIT_en)
                    state_d = START_SB_PATTERN;
`endif
            end
            START_SB_PATTERN: begin
                if (i_SB_pattern_detected)
                    state_d = SBINIT_OUT_OF_RESET;
            end
            SBINIT_OUT_OF_RESET: begin
                sent_d = sent | i_deassert_valid;
                rcvd_d = rcvd | (i_decoded_SB_msg == MSG_OUT_OF_RESET);
                if (sent_d && rcvd_d) begin
                    state_d = SBINIT_DONE_REQ;
                    sent_d  = 1'b0;
                    rcvd_d  = 1'b0;
                end
            end
            SBINIT_DONE_REQ: begin
                sent_d = sent | i_deassert_valid;
                rcvd_d = rcvd | (i_decoded_SB_msg == MSG_DONE_RESP);
                if (sent_d && rcvd_d) begin
                    state_d = SBINIT_END;
                    sent_d  = 1'b0;
                    rcvd_d  = 1'b0;
                end
            end
            SBINIT_END: ;
            default: state_d = IDLE;
        endcase

`ifdef SBINIT_TIMEOUT_EN
        // The budget spans all three active states; it only restarts from IDLE.
        if (state inside {START_SB_PATTERN, SBINIT_OUT_OF_RESET, SBINIT_DONE_REQ}) begin
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = IDLE;
                sent_d    = 1'b0;
                rcvd_d    = 1'b0;
                cnt_d     = '0;
                lockout_d = 1'b1;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
`endif

        // Dropping the enable overrides everything, including a same-cycle timeout.
        if (state != IDLE && !i_SBINIT_en) begin
            state_d   = IDLE;
            sent_d    = 1'b0;
            rcvd_d    = 1'b0;
            timeout_d = 1'b0;
`ifdef SBINIT_TIMEOUT_EN
            cnt_d     = '0;
            lockout_d = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= IDLE;
            sent                <= 1'b0;
            rcvd                <= 1'b0;
            o_start_pattern_req <= 1'b0;
            o_valid_tx          <= 1'b0;
            o_encoded_SB_msg_tx <= MSG_NONE;
            o_SBINIT_end_tx     <= 1'b0;
`ifdef SBINIT_TIMEOUT_EN
            cnt                 <= '0;
            lockout             <= 1'b0;
            o_SBINIT_timeout    <= 1'b0;
`endif
        end else begin
            state               <= state_d;
            sent                <= sent_d;
            rcvd                <= rcvd_d;
            o_start_pattern_req <= (state_d == START_SB_PATTERN);
            o_valid_tx          <= (state_d == SBINIT_OUT_OF_RESET || state_d == SBINIT_DONE_REQ) && !sent_d;
            o_encoded_SB_msg_tx <= (state_d == SBINIT_OUT_OF_RESET) ? MSG_OUT_OF_RESET :
                                   (state_d == SBINIT_DONE_REQ)     ? MSG_DONE_REQ     : MSG_NONE;
            o_SBINIT_end_tx     <= (state_d == SBINIT_END);
`ifdef SBINIT_TIMEOUT_EN
            cnt                 <= cnt_d;
            lockout             <= lockout_d;
            o_SBINIT_timeout    <= timeout_d;
`endif
        end
    end

`ifndef SBINIT_TIMEOUT_EN
    assign o_SBINIT_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tx_sbinit.sv
// Bench for tx_sbinit: directed vector table, reset/timeout sequences and randomized
// stimulus compared against a stage-level reference model.
module tb_tx_sbinit;

    localparam int W    = 4;
    localparam int TOUT = 50;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_SBINIT_en;
    logic         i_SB_pattern_detected;
    logic [W-1:0] i_decoded_SB_msg;
    logic         i_deassert_valid;
    logic         o_start_pattern_req;
    logic         o_valid_tx;
    logic [W-1:0] o_encoded_SB_msg_tx;
    logic         o_SBINIT_end_tx;
    logic         o_SBINIT_timeout;

    tx_sbinit #(.SB_MSG_WIDTH(W), .TIMEOUT_CYCLES(TOUT)) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_SBINIT_en           (i_SBINIT_en),
        .i_SB_pattern_detected (i_SB_pattern_detected),
        .i_decoded_SB_msg      (i_decoded_SB_msg),
        .i_deassert_valid      (i_deassert_valid),
        .o_start_pattern_req   (o_start_pattern_req),
        .o_valid_tx            (o_valid_tx),
        .o_encoded_SB_msg_tx   (o_encoded_SB_msg_tx),
        .o_SBINIT_end_tx       (o_SBINIT_end_tx),
        .o_SBINIT_timeout      (o_SBINIT_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stage 0 idle, 1 pattern, 2 out-of-reset msg, 3 done msg, 4 end.
    int m_stage, m_cnt;
    bit m_sent, m_rcvd, m_lock, m_tmo;

    typedef struct {
        logic         en;
        logic         pat;
        logic [W-1:0] dec;
        logic         dv;
        logic [7:0]   exp;
        string        name;
    } vec_t;

    vec_t vq[$];

    function automatic logic [7:0] pk(input logic s, input logic v, input logic [W-1:0] e,
                                      input logic n, input logic t);
        return {s, v, e, n, t};
    endfunction

    function automatic logic [7:0] dut_out();
        return pk(o_start_pattern_req, o_valid_tx, o_encoded_SB_msg_tx, o_SBINIT_end_tx, o_SBINIT_timeout);
    endfunction

    function automatic logic [7:0] model_out();
        logic [W-1:0] code;
        code = (m_stage == 2 || m_stage == 3) ? W'(m_stage - 1) : '0;
        return pk(m_stage == 1, (m_stage == 2 || m_stage == 3) && !m_sent, code, m_stage == 4, m_tmo);
    endfunction

    task automatic model_reset();
        m_stage = 0; m_cnt = 0; m_sent = 0; m_rcvd = 0; m_lock = 0; m_tmo = 0;
    endtask

    task automatic model_update();
        bit timed_out;
        int want;
        m_tmo = 0;
        timed_out = 0;
        if (!i_SBINIT_en) begin
            model_reset();
        end else if (m_stage == 0) begin
            if (!m_lock) m_stage = 1;
        end else if (m_stage >= 1 && m_stage <= 3) begin
`ifdef SBINIT_TIMEOUT_EN
            if (m_cnt == TOUT - 1) begin
                timed_out = 1;
                m_stage = 0; m_cnt = 0; m_sent = 0; m_rcvd = 0; m_lock = 1; m_tmo = 1;
            end else begin
                m_cnt++;
            end
`endif
            if (!timed_out) begin
                if (m_stage == 1) begin
                    if (i_SB_pattern_detected) m_stage = 2;
                end else begin
                    want = (m_stage == 2) ? 1 : 3;
                    if (i_deassert_valid) m_sent = 1;
                    if (int'(i_decoded_SB_msg) == want) m_rcvd = 1;
                    if (m_sent && m_rcvd) begin
                        m_stage++;
                        m_sent = 0;
                        m_rcvd = 0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {start,valid,code,end,tmo}=%b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, update the model, then settle.
    task automatic step(input logic en, input logic pat, input logic [W-1:0] dec, input logic dv);
        i_SBINIT_en           = en;
        i_SB_pattern_detected = pat;
        i_decoded_SB_msg      = dec;
        i_deassert_valid      = dv;
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic add_vec(input logic en, input logic pat, input logic [W-1:0] dec, input logic dv,
                           input logic s, input logic v, input logic [W-1:0] e, input logic n,
                           input string name);
        vec_t t;
        t.en = en; t.pat = pat; t.dec = dec; t.dv = dv;
        t.exp = pk(s, v, e, n, 1'b0);
        t.name = name;
        vq.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0;
        i_SBINIT_en = 0; i_SB_pattern_detected = 0; i_decoded_SB_msg = '0; i_deassert_valid = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("reset outputs", dut_out(), 8'h00);
        i_rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("idle after reset", dut_out(), 8'h00);

        //       en pat dec dv   start valid code end
        add_vec(1, 1, 1, 1,     1, 0, 0, 0, "min idle->start");
        add_vec(1, 1, 1, 1,     0, 1, 1, 0, "min start->oor");
        add_vec(1, 1, 1, 1,     0, 1, 2, 0, "min oor->done");
        add_vec(1, 1, 3, 1,     0, 0, 0, 1, "min done->end");
        add_vec(1, 0, 0, 0,     0, 0, 0, 1, "end held");
        add_vec(0, 0, 0, 0,     0, 0, 0, 0, "end->idle");
        add_vec(1, 0, 0, 0,     1, 0, 0, 0, "enter start");
        add_vec(1, 0, 0, 0,     1, 0, 0, 0, "wait pattern");
        add_vec(1, 1, 0, 0,     0, 1, 1, 0, "pattern->oor");
        add_vec(1, 0, 3, 0,     0, 1, 1, 0, "done_resp ignored in oor");
        add_vec(1, 0, 1, 0,     0, 1, 1, 0, "early rcvd holds");
        add_vec(1, 0, 0, 1,     0, 1, 2, 0, "deassert->done_req");
        add_vec(1, 0, 0, 1,     0, 0, 2, 0, "done_req sent");
        add_vec(1, 0, 0, 0,     0, 0, 2, 0, "stale resp not credited");
        add_vec(1, 0, 1, 0,     0, 0, 2, 0, "code1 ignored in done_req");
        add_vec(1, 0, 3, 0,     0, 0, 0, 1, "done_resp->end");
        add_vec(0, 0, 0, 0,     0, 0, 0, 0, "idle again");
        add_vec(1, 0, 0, 0,     1, 0, 0, 0, "abort seq start");
        add_vec(1, 1, 0, 0,     0, 1, 1, 0, "abort seq oor");
        add_vec(1, 0, 1, 1,     0, 1, 2, 0, "abort seq done_req valid");
        add_vec(0, 0, 0, 0,     0, 0, 0, 0, "abort drops valid");
        add_vec(1, 0, 0, 0,     1, 0, 0, 0, "restart after abort");
        add_vec(0, 0, 0, 0,     0, 0, 0, 0, "idle before reset test");

        foreach (vq[i]) begin
            step(vq[i].en, vq[i].pat, vq[i].dec, vq[i].dv);
            check(vq[i].name, dut_out(), vq[i].exp);
        end

        // Asynchronous reset in the middle of START_SB_PATTERN.
        step(1, 0, 0, 0);
        check("pre-reset start", dut_out(), pk(1, 0, 0, 0, 0));
        i_rst_n = 1'b0;
        #1;
        check("async reset clears", dut_out(), 8'h00);
        model_reset();
        i_SBINIT_en = 0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(0, 0, 0, 0);
        check("idle after mid reset", dut_out(), 8'h00);
        step(1, 0, 0, 0);
        check("start after mid reset", dut_out(), pk(1, 0, 0, 0, 0));
        step(0, 0, 0, 0);

`ifdef SBINIT_TIMEOUT_EN
        step(1, 0, 0, 0);
        check("tmo entry", dut_out(), pk(1, 0, 0, 0, 0));
        for (int j = 1; j < TOUT; j++) begin
            step(1, 0, 0, 0);
            check("tmo waiting", dut_out(), pk(1, 0, 0, 0, 0));
        end
        step(1, 0, 0, 0);
        check("tmo pulse", dut_out(), pk(0, 0, 0, 0, 1));
        for (int j = 0; j < 3; j++) begin
            step(1, 1, 0, 0);
            check("tmo lockout", dut_out(), 8'h00);
        end
        step(0, 0, 0, 0);
        check("tmo en low", dut_out(), 8'h00);
        step(1, 0, 0, 0);
        check("tmo restart", dut_out(), pk(1, 0, 0, 0, 0));
        for (int j = 1; j < TOUT; j++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("tmo vs deassert", dut_out(), 8'h00);
        step(1, 0, 0, 0);
        check("no lockout after deassert", dut_out(), pk(1, 0, 0, 0, 0));
        step(0, 0, 0, 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            int d;
            d = $urandom_range(0, 7);
            step($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0,
                 (d > 3) ? W'(d - 4) : W'(0), $urandom_range(0, 2) == 0);
            check("random vs model", dut_out(), model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_sbinit.md
# tx_sbinit

Initiator half of the LTSM SBINIT step. Drives the sideband start-pattern request, sends the SBINIT out-of-reset message, and issues the SBINIT done request. It then waits for the partner's done response and raises a completion flag. The LTSM wrapper combines `o_SBINIT_end_tx` with the receive-side responder's `o_SBINIT_end_rx`; both share the same sideband message encoder/decoder.

## Interface
Parameters:
- `SB_MSG_WIDTH`, 4: width of encoded/decoded sideband message codes.
- `TIMEOUT_CYCLES`, 800000: SBINIT timeout in `i_clk` cycles (8 ms at 100 MHz); counter width `$clog2(TIMEOUT_CYCLES)`.

Message codes (localparams):
- 0 = none
- 1 = SBINIT_out_of_reset
- 2 = SBINIT_done_req
- 3 = SBINIT_done_resp

Ports:
- `i_clk`  in  1  sideband logic clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_SBINIT_en`  in  1  LTSM enable; level, held high for the whole SBINIT step.
- `i_SB_pattern_detected`  in  1  level from the pattern detector: partner's clock pattern detected.
- `i_decoded_SB_msg`  in  `SB_MSG_WIDTH`  last decoded received message code; 0 = none.
- `i_deassert_valid`  in  1  encoder has consumed the current message; may be multi-cycle.
- `o_start_pattern_req`  out  1  request to the pattern generator to send the SB clock pattern.
- `o_valid_tx`  out  1  `o_encoded_SB_msg_tx` is valid to the encoder.
- `o_encoded_SB_msg_tx`  out  `SB_MSG_WIDTH`  message code to send.
- `o_SBINIT_end_tx`  out  1  initiator side finished.
- `o_SBINIT_timeout`  out  1  one-cycle pulse on timeout.

## Operation
States: IDLE, START_SB_PATTERN, SBINIT_OUT_OF_RESET, SBINIT_DONE_REQ, SBINIT_END.

- **IDLE**
  - All outputs 0.
  - `i_SBINIT_en`=1 and no timeout lockout → START_SB_PATTERN.
- **START_SB_PATTERN**
  - `o_start_pattern_req`=1.
  - `i_SB_pattern_detected`=1 → SBINIT_OUT_OF_RESET.
- **SBINIT_OUT_OF_RESET**
  - `o_encoded_SB_msg_tx`=1.
  - `o_valid_tx` rises on entry and stays high until `i_deassert_valid` is sampled high; it is never reasserted in the same state (`sent` flag).
  - `i_decoded_SB_msg`==1 sets `rcvd` flag; this can happen before, during or after the send.
  - Transition to SBINIT_DONE_REQ when `sent` and `rcvd` are both set, counting values captured this cycle.
- **SBINIT_DONE_REQ**
  - `o_encoded_SB_msg_tx`=2; same valid/`sent` rule; `rcvd` set by code 3.
  - Transition to SBINIT_END when `sent` and `rcvd` are both set.
- **SBINIT_END**
  - `o_SBINIT_end_tx`=1; encoded message and valid are 0.
  - `i_SBINIT_en`=0 → IDLE.
- `sent` and `rcvd` clear on every state change.
- Any non-IDLE state with `i_SBINIT_en`=0 → IDLE next edge; all flags and the timeout counter clear. This takes priority over every other transition.
- Codes other than the one expected in the current state are ignored. A done_resp arriving during OUT_OF_RESET is not remembered.

## Timing
- Reset: state IDLE; every output 0; flags 0; counter 0.
- Outputs are decoded from the registered state plus flags, with no combinational path from inputs.
  - `i_SBINIT_en` sampled high at edge k → `o_start_pattern_req`=1 from k through the edge where the pattern is detected.
  - On entry to a message state at edge n, `o_valid_tx`=1 from n.
  - `i_deassert_valid` sampled at edge m → `o_valid_tx`=0 from m.
- Minimum path IDLE→END is 4 edges when every condition is already present.
- `o_SBINIT_end_tx` stays high while `i_SBINIT_en` stays high.

## Configuration
- `SBINIT_TIMEOUT_EN` defined:
  - Counter increments every cycle in START_SB_PATTERN, SBINIT_OUT_OF_RESET and SBINIT_DONE_REQ; it does not reset between these states.
  - At count `TIMEOUT_CYCLES-1`: `o_SBINIT_timeout` pulses 1 cycle and the state goes to IDLE.
  - A lockout flag then holds IDLE until `i_SBINIT_en` is seen low, after which a new rise restarts.
  - A timeout and an en-deassert in the same cycle: deassert wins, no pulse.
- Not defined: no counter or lockout; `o_SBINIT_timeout` is tied 0.

## Test plan
- Reset mid-START_SB_PATTERN with `i_rst_n`=0 for 1 cycle → all outputs 0 immediately, state IDLE.
- Normal: en=1; pattern_detected after 10 cycles; decoded=1 five cycles later; deassert_valid 2 cycles; decoded=2 then 3 → `o_encoded_SB_msg_tx` goes 1 then 2, valid drops per deassert, `o_SBINIT_end_tx`=1; en=0 → IDLE next edge.
- Early receive: decoded=1 arrives before `i_deassert_valid` → stays in OUT_OF_RESET until deassert, then moves to DONE_REQ on that edge.
- Wrong code: decoded=3 during OUT_OF_RESET, then 1 → no transition until code 1 arrives; 3 is not credited in DONE_REQ.
- Abort: en=0 during DONE_REQ with valid high → valid=0 and IDLE next edge; re-enable restarts at START_SB_PATTERN.
- With `SBINIT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50: pattern never detected → `o_SBINIT_timeout` pulses 50 cycles after entry, IDLE held while en stays 1; en 0→1 restarts.
